// File: rtl/ext_bus_uart_bridge.sv
// Bridges a CPU external bus cycle onto a byte-wide UART link: command, address,
// optional write data out, and for reads one reply byte back with a timeout fallback.
//
// state     | meaning
// IDLE      | waiting for req; no UART traffic owned
// SEND_CMD  | sending READ_CMD / WRITE_CMD
// SEND_AH   | sending latched address high byte
// SEND_AL   | sending latched address low byte
// SEND_DATA | sending latched write data (writes only)
// WAIT_RX   | waiting for the read reply byte, counting toward timeout
// DONE      | issuing the one-cycle ready (and timeout) pulse
module ext_bus_uart_bridge #(
  parameter int           TIMEOUT_CYCLES = 1023,
  parameter logic [7:0]   READ_CMD       = 8'h52,
  parameter logic [7:0]   WRITE_CMD      = 8'h57,
  parameter logic [7:0]   FAULT_DATA     = 8'hEA
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] addr_high,
  input  logic [7:0] addr_low,
  input  logic [7:0] db_write,
  output logic [7:0] db_read,
  output logic       ready,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] txdata,
  output logic       txclk,
  input  logic       txready,
  input  logic [7:0] rxdata,
  input  logic       rxready,
  output logic       rxclk
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND_CMD  = 3'd1;
  localparam logic [2:0] SEND_AH   = 3'd2;
  localparam logic [2:0] SEND_AL   = 3'd3;
  localparam logic [2:0] SEND_DATA = 3'd4;
  localparam logic [2:0] WAIT_RX   = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  localparam logic [10:0] TMO_CNT = TIMEOUT_CYCLES[10:0];

  logic [2:0]  state;
  logic        rw_q;
  logic [7:0]  ah_q;
  logic [7:0]  al_q;
  logic [7:0]  wd_q;
  logic [10:0] wait_cnt;
  logic        to_flag;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      rw_q     <= 1'b0;
      ah_q     <= 8'h00;
      al_q     <= 8'h00;
      wd_q     <= 8'h00;
      wait_cnt <= 11'd0;
      to_flag  <= 1'b0;
      db_read  <= 8'h00;
      txdata   <= 8'h00;
      txclk    <= 1'b0;
      rxclk    <= 1'b0;
      ready    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      txclk   <= 1'b0;
      ready   <= 1'b0;
      timeout <= 1'b0;
      // Outside WAIT_RX any received byte is stale: pop it without touching db_read.
      rxclk   <= rxready && (state != WAIT_RX);

      case (state)
        IDLE: begin
          if (req) begin
            rw_q  <= rw;
            ah_q  <= addr_high;
            al_q  <= addr_low;
            wd_q  <= db_write;
            state <= SEND_CMD;
          end
        end
        SEND_CMD: begin
          if (txready) begin
            txdata <= rw_q ? READ_CMD : WRITE_CMD;
            txclk  <= 1'b1;
            state  <= SEND_AH;
          end
        end
        SEND_AH: begin
          if (txready) begin
            txdata <= ah_q;
            txclk  <= 1'b1;
            state  <= SEND_AL;
          end
        end
        SEND_AL: begin
          if (txready) begin
            txdata   <= al_q;
            txclk    <= 1'b1;
            wait_cnt <= 11'd0;
            to_flag  <= 1'b0;
            state    <= rw_q ? WAIT_RX : SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (txready) begin
            txdata <= wd_q;
            txclk  <= 1'b1;
            state  <= DONE;
          end
        end
        WAIT_RX: begin
          // A byte arriving on the timeout cycle still wins.
          if (rxready) begin
            db_read <= rxdata;
            rxclk   <= 1'b1;
            state   <= DONE;
          end else if (wait_cnt == TMO_CNT) begin
            db_read <= FAULT_DATA;
            to_flag <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 11'd1;
          end
        end
        DONE: begin
          ready   <= 1'b1;
          timeout <= to_flag;
          to_flag <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_uart_bridge.sv
// Scoreboard bench for ext_bus_uart_bridge: the driver pushes expected UART bytes and
// bus responses from a transaction-level model; a negedge monitor pops and compares.
module tb_ext_bus_uart_bridge;

  logic       clk = 1'b0;
  logic       nrst;
  logic       req;
  logic       rw;
  logic [7:0] addr_high;
  logic [7:0] addr_low;
  logic [7:0] db_write;
  logic [7:0] db_read;
  logic       ready;
  logic       busy;
  logic       timeout;
  logic [7:0] txdata;
  logic       txclk;
  logic       txready;
  logic [7:0] rxdata;
  logic       rxready;
  logic       rxclk;

  typedef struct {
    logic [7:0] dbr;
    logic       to;
    int         cyc;
  } resp_t;

  logic [7:0] tx_q[$];
  resp_t      resp_q[$];
  logic [7:0] model_dbr = 8'h00;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  ext_bus_uart_bridge dut (
    .clk(clk), .nrst(nrst), .req(req), .rw(rw),
    .addr_high(addr_high), .addr_low(addr_low), .db_write(db_write),
    .db_read(db_read), .ready(ready), .busy(busy), .timeout(timeout),
    .txdata(txdata), .txclk(txclk), .txready(txready),
    .rxdata(rxdata), .rxready(rxready), .rxclk(rxclk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every strobe and every completion is checked against the queues.
  always @(negedge clk) begin
    if (nrst) begin
      if (txclk) begin
        if (tx_q.size() == 0) fail_now("tx_unexpected_strobe");
        else check("txdata", {24'h0, txdata}, {24'h0, tx_q.pop_front()});
      end
      if (ready) begin
        if (resp_q.size() == 0) fail_now("ready_unexpected");
        else begin
          resp_t r;
          r = resp_q.pop_front();
          check("db_read_at_ready", {24'h0, db_read}, {24'h0, r.dbr});
          check("timeout_at_ready", {31'h0, timeout}, {31'h0, r.to});
          if (r.cyc >= 0) check("ready_cycle", cyc, r.cyc);
        end
      end else if (timeout) begin
        fail_now("timeout_without_ready");
      end
    end
  end

  // One bus transaction. rx_delay < 0 means no reply (timeout); stall holds txready
  // low that many cycles in SEND_AH; rnd randomizes txready every cycle.
  task automatic run_txn(input logic t_rw, input logic [7:0] ah, input logic [7:0] al,
                         input logic [7:0] wd, input logic [7:0] rxb,
                         input int rx_delay, input int stall, input bit rnd);
    int    n_tx = 0;
    int    rxc = 0;
    int    guard = 0;
    int    stall_left = stall;
    bit    in_wait = 0;
    bit    rx_sent = 0;
    bit    done = 0;
    bit    prev_txr = 1;
    resp_t r;
    rw = t_rw; addr_high = ah; addr_low = al; db_write = wd;
    req = 1'b1; txready = 1'b1; rxready = 1'b0;
    tx_q.push_back(t_rw ? 8'h52 : 8'h57);
    tx_q.push_back(ah);
    tx_q.push_back(al);
    if (!t_rw) tx_q.push_back(wd);
    if (t_rw) model_dbr = (rx_delay < 0) ? 8'hEA : rxb;
    r.dbr = model_dbr;
    r.to  = t_rw && (rx_delay < 0);
    r.cyc = rnd ? -1 : cyc + 1 + 5 + stall + (t_rw ? ((rx_delay < 0) ? 1023 : rx_delay) : 0);
    resp_q.push_back(r);
    while (!done && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (!prev_txr) check("txclk_while_stalled", {31'h0, txclk}, 32'h0);
      if (rx_sent) begin
        check("rxclk_on_take", {31'h0, rxclk}, 32'h1);
        rx_sent = 0;
      end
      rxready = 1'b0;
      rxdata = 8'($urandom);
      if (txclk) begin
        n_tx++;
        if (t_rw && n_tx == 3) in_wait = 1;
      end
      if (ready) begin
        done = 1;
        req = 1'b0;
      end else begin
        // Inputs churn while busy; the DUT must work from its latched copies.
        req = 1'($urandom);
        rw = 1'($urandom);
        addr_high = 8'($urandom);
        addr_low = 8'($urandom);
        db_write = 8'($urandom);
        if (in_wait && rx_delay >= 0) begin
          if (rxc == rx_delay) begin
            rxready = 1'b1;
            rxdata = rxb;
            rx_sent = 1;
          end
          rxc++;
        end
      end
      if (rnd) txready = 1'($urandom);
      else if (n_tx == 1 && stall_left > 0) begin
        txready = 1'b0;
        stall_left--;
      end else txready = 1'b1;
      prev_txr = txready;
    end
    req = 1'b0; txready = 1'b1; rxready = 1'b0;
    if (!done) fail_now("txn_no_ready_within_budget");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_ready"}, {31'h0, ready}, 32'h0);
    check({tag, "_timeout"}, {31'h0, timeout}, 32'h0);
    check({tag, "_txclk"}, {31'h0, txclk}, 32'h0);
    check({tag, "_rxclk"}, {31'h0, rxclk}, 32'h0);
    check({tag, "_db_read"}, {24'h0, db_read}, 32'h0);
    check({tag, "_txdata"}, {24'h0, txdata}, 32'h0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog_expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_tx;
    int guard;
    int ready_seen;
    nrst = 1'b0; req = 1'b0; rw = 1'b0; addr_high = 8'h00; addr_low = 8'h00;
    db_write = 8'h00; txready = 1'b1; rxdata = 8'h00; rxready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rxready = 1'b0;
    nrst = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 8'h12, 8'hAB, 8'h00, 8'h3C, 0, 0, 0);
    run_txn(1'b0, 8'hFF, 8'hFE, 8'h99, 8'h00, 0, 0, 0);
    run_txn(1'b0, 8'h40, 8'h01, 8'h5A, 8'h00, 0, 3, 0);
    run_txn(1'b1, 8'h80, 8'h7F, 8'h00, 8'hC3, 2, 3, 0);
    run_txn(1'b1, 8'h00, 8'h10, 8'h00, 8'h00, -1, 0, 0);

    // Stale byte in IDLE is popped and discarded.
    repeat (2) @(negedge clk);
    rxready = 1'b1; rxdata = 8'h77;
    @(negedge clk);
    rxready = 1'b0;
    check("stale_rxclk", {31'h0, rxclk}, 32'h1);
    check("stale_db_read", {24'h0, db_read}, {24'h0, model_dbr});
    @(negedge clk);

    run_txn(1'b1, 8'h01, 8'h02, 8'h00, 8'h5A, 1023, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic t_rw;
      int   d;
      t_rw = 1'($urandom);
      d = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 15));
      run_txn(t_rw, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), d, 0, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while SEND_AL is pending aborts the read without a ready pulse.
    rw = 1'b1; addr_high = 8'h12; addr_low = 8'h34; req = 1'b1; txready = 1'b1;
    tx_q.push_back(8'h52); tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    n_tx = 0; guard = 0;
    while (n_tx < 2 && guard < 50) begin
      @(negedge clk);
      req = 1'b0;
      guard++;
      if (txclk) n_tx++;
    end
    if (n_tx < 2) fail_now("reset_setup_no_strobes");
    nrst = 1'b0;
    @(negedge clk);
    tx_q.delete();
    resp_q.delete();
    model_dbr = 8'h00;
    check_reset_outputs("midreset");
    nrst = 1'b1;
    ready_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready || txclk || busy) ready_seen++;
    end
    check("midreset_quiet_after", ready_seen, 0);

    run_txn(1'b1, 8'hA5, 8'h5A, 8'h00, 8'h81, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("tx_queue_drained", tx_q.size(), 0);
    check("resp_queue_drained", resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
